// File: rtl/spi_slave_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_fifo_if
// Description : Host-side register/FIFO interface of the SPI responder.
//               master modport = host logic, slave modport = spi_slave_fifo.
//   CONTROL        [7]=EN, [1]=CPOL, [0]=CPHA
//   WRITE          1-cycle pulse, push INCOMING_DATA into the TX FIFO
//   INCOMING_DATA  byte to transmit
//   READ           1-cycle pulse, pop the RX FIFO
//   OUTCOMING_DATA RX FIFO head (show-ahead), 8'h00 when empty
//   ERR_CLR        1-cycle pulse, clear sticky error bits
//   STATUS         {FRAME_ERR, TX_UNDERRUN, RX_OVERFLOW, BUSY,
//                   TX_FULL, TX_EMPTY, RX_FULL, RX_NOT_EMPTY}
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_fifo_if;
  logic [7:0] CONTROL;
  logic       WRITE;
  logic [7:0] INCOMING_DATA;
  logic       READ;
  logic [7:0] OUTCOMING_DATA;
  logic       ERR_CLR;
  logic [7:0] STATUS;

  modport master (
    output CONTROL, WRITE, INCOMING_DATA, READ, ERR_CLR,
    input  OUTCOMING_DATA, STATUS
  );

  modport slave (
    input  CONTROL, WRITE, INCOMING_DATA, READ, ERR_CLR,
    output OUTCOMING_DATA, STATUS
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_fifo
// Description : SPI responder (modes 0-3, MSB first) with TX/RX byte FIFOs.
//               The SPI pins are oversampled in the CLK domain.
//   CLK   local clock (>= 4x S_CLK)      CLR  async reset, active-low
//   host  spi_slave_fifo_if.slave        host FIFO / control / status port
//   S_CLK, CS, MOSI  SPI inputs          MISO SPI output, Z when not selected
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_fifo #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic       CLK,
  input  wire logic       CLR,
  spi_slave_fifo_if.slave host,
  input  wire logic       S_CLK,
  input  wire logic       CS,
  input  wire logic       MOSI,
  output logic            MISO
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0]             tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   load_pend_q, load_pend_d; // byte done, next shift edge loads
  logic                   hold_q, hold_d;           // CPHA=1: first shift edge keeps the preload
  logic                   und_pend_q, und_pend_d;   // dummy loaded, flag once it is clocked
  logic [2:0]             err_q, err_d;             // {frame, underrun, overflow}
  logic [7:0]             tx_mem_q [FIFO_DEPTH];
  logic [7:0]             tx_mem_d [FIFO_DEPTH];
  logic [7:0]             rx_mem_q [FIFO_DEPTH];
  logic [7:0]             rx_mem_d [FIFO_DEPTH];
  ptr_t                   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  ptr_t                   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  logic sclk_s, cs_s, mosi_s, rise, fall, sample_edge, shift_edge, cs_fall, cs_rise;
  logic en, tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_load;
  logic [2:0] err_set;
  logic [7:0] rx_byte;
  logic unused_ctrl;

  assign unused_ctrl = ^host.CONTROL[6:2];
  assign en       = host.CONTROL[7];
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  // Leading edge is the edge leaving the idle level set by CPOL.
  assign sample_edge = cpha_q ? (cpol_q ? rise : fall) : (cpol_q ? fall : rise);
  assign shift_edge  = cpha_q ? (cpol_q ? fall : rise) : (cpol_q ? rise : fall);
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_byte  = {rx_sr_q[6:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], S_CLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    load_pend_d = load_pend_q;
    hold_d      = hold_q;
    und_pend_d  = und_pend_q;
    err_set     = 3'b000;
    tx_load     = 1'b0;
    rx_push     = 1'b0;
    tx_push     = host.WRITE && !tx_full;
    rx_pop      = host.READ && !rx_empty;

    case (state_q)
      IDLE: begin
        if (cs_s) begin
          cpol_d = host.CONTROL[1];
          cpha_d = host.CONTROL[0];
        end
        if (en && cs_fall) begin
          state_d     = ACTIVE;
          bit_cnt_d   = 3'd0;
          load_pend_d = 1'b0;
          und_pend_d  = 1'b0;
          hold_d      = cpha_q;
          tx_load     = 1'b1;
          err_set[1]  = tx_empty;
        end
      end
      ACTIVE: begin
        if (!en || cs_rise) begin
          state_d     = IDLE;
          err_set[2]  = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
          load_pend_d = 1'b0;
          hold_d      = 1'b0;
          und_pend_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sr_d = rx_byte;
            // A dummy loaded at the end of the previous byte only counts as
            // an underrun once the master actually clocks it.
            if (und_pend_q) begin
              err_set[1] = 1'b1;
              und_pend_d = 1'b0;
            end
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = 3'd0;
              load_pend_d = 1'b1;
              if (rx_full) err_set[0] = 1'b1;
              else         rx_push    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          if (shift_edge) begin
            if (hold_q) begin
              hold_d = 1'b0;
            end else if (load_pend_q) begin
              load_pend_d = 1'b0;
              tx_load     = 1'b1;
              und_pend_d  = tx_empty;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_pop = 1'b0;
    if (tx_load) begin
      if (!tx_empty) begin
        tx_sr_d = tx_mem_q[tx_rd_q[AW-1:0]];
        tx_pop  = 1'b1;
      end else begin
        tx_sr_d = DUMMY_BYTE;
      end
    end

    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q[AW-1:0]] = host.INCOMING_DATA;
      tx_wr_d = tx_wr_q + PTR_ONE;
    end
    if (tx_pop) tx_rd_d = tx_rd_q + PTR_ONE;
    if (rx_push) begin
      rx_mem_d[rx_wr_q[AW-1:0]] = rx_byte;
      rx_wr_d = rx_wr_q + PTR_ONE;
    end
    if (rx_pop) rx_rd_d = rx_rd_q + PTR_ONE;

    // A bit being set in this cycle survives a coincident clear.
    err_d = host.ERR_CLR ? err_set : (err_q | err_set);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_sr_q     <= DUMMY_BYTE;
      rx_sr_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      load_pend_q <= 1'b0;
      hold_q      <= 1'b0;
      und_pend_q  <= 1'b0;
      err_q       <= 3'b000;
      tx_mem_q    <= '{default: 8'h00};
      rx_mem_q    <= '{default: 8'h00};
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      load_pend_q <= load_pend_d;
      hold_q      <= hold_d;
      und_pend_q  <= und_pend_d;
      err_q       <= err_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
    end
  end

  assign host.OUTCOMING_DATA = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign host.STATUS = {err_q[2], err_q[1], err_q[0], (state_q == ACTIVE),
                        tx_full, tx_empty, rx_full, ~rx_empty};
  assign MISO = ((state_q == ACTIVE) && en) ? tx_sr_q[7] : 1'bz;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_fifo
// Description : Directed self-checking bench for spi_slave_fifo: an SPI
//               master model plus host pulses, expected values hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_fifo;
  localparam int H = 5; // S_CLK half period in CLK cycles

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic s_clk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  wire  miso;
  wire  miso_z = (miso === 1'bz);
  int   n_checks = 0;
  int   n_fail = 0;

  spi_slave_fifo_if host_if ();

  spi_slave_fifo #(
    .FIFO_DEPTH (4),
    .DUMMY_BYTE (8'hFF),
    .SYNC_STAGES(2)
  ) dut (
    .CLK  (clk),
    .CLR  (clr_n),
    .host (host_if.slave),
    .S_CLK(s_clk),
    .CS   (cs),
    .MOSI (mosi),
    .MISO (miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] b);
    host_if.INCOMING_DATA = b;
    host_if.WRITE = 1'b1;
    @(negedge clk);
    host_if.WRITE = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_read();
    host_if.READ = 1'b1;
    @(negedge clk);
    host_if.READ = 1'b0;
    @(negedge clk);
  endtask

  task automatic err_clr();
    host_if.ERR_CLR = 1'b1;
    @(negedge clk);
    host_if.ERR_CLR = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_begin(input logic [1:0] mode);
    host_if.CONTROL = {1'b1, 5'b00000, mode};
    s_clk = mode[1];
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Master: shifts n bits of tx (MSB first), returns the bits seen on MISO.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    logic cpol, cpha;
    logic [7:0] sh;
    cpol = host_if.CONTROL[1];
    cpha = host_if.CONTROL[0];
    sh = tx;
    rx = 8'h00;
    if (!cpha) mosi = sh[7];
    for (int i = 0; i < n; i++) begin
      repeat (H) @(negedge clk);
      if (cpha) begin
        s_clk = ~cpol;
        mosi = sh[7];
      end else begin
        rx = {rx[6:0], miso};
        s_clk = ~cpol;
      end
      repeat (H) @(negedge clk);
      s_clk = cpol;
      if (cpha) rx = {rx[6:0], miso};
      sh = sh << 1;
      if (!cpha) mosi = sh[7];
    end
  endtask

  initial begin
    logic [7:0] r;
    host_if.CONTROL = 8'h80;
    host_if.WRITE = 1'b0;
    host_if.READ = 1'b0;
    host_if.ERR_CLR = 1'b0;
    host_if.INCOMING_DATA = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", host_if.STATUS, 8'h04);
    check("rst_out", host_if.OUTCOMING_DATA, 8'h00);
    check("rst_miso_z", {7'd0, miso_z}, 8'h01);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, single byte
    host_write(8'h4D);
    check("m0_status_tx", host_if.STATUS, 8'h00);
    frame_begin(2'b00);
    check("m0_busy", host_if.STATUS, 8'h14);
    check("m0_miso_driven", {7'd0, miso_z}, 8'h00);
    spi_bits(8'h50, 8, r);
    check("m0_miso_byte", r, 8'h4D);
    frame_end();
    check("m0_status", host_if.STATUS, 8'h05);
    check("m0_out", host_if.OUTCOMING_DATA, 8'h50);
    check("m0_miso_z", {7'd0, miso_z}, 8'h01);
    host_read();
    check("m0_status_rd", host_if.STATUS, 8'h04);
    check("m0_out_rd", host_if.OUTCOMING_DATA, 8'h00);

    // Mode 3, two-byte frame
    host_write(8'h54);
    host_write(8'h6C);
    frame_begin(2'b11);
    spi_bits(8'hA5, 8, r);
    check("m3_miso_b0", r, 8'h54);
    spi_bits(8'h3C, 8, r);
    check("m3_miso_b1", r, 8'h6C);
    frame_end();
    check("m3_status", host_if.STATUS, 8'h05);
    check("m3_out0", host_if.OUTCOMING_DATA, 8'hA5);
    host_read();
    check("m3_out1", host_if.OUTCOMING_DATA, 8'h3C);
    host_read();
    check("m3_status_rd", host_if.STATUS, 8'h04);

    // Underrun and overflow: empty TX FIFO, five bytes into a 4-deep RX FIFO
    frame_begin(2'b00);
    check("uo_status_start", host_if.STATUS, 8'h54);
    for (int b = 1; b <= 5; b++) begin
      spi_bits(8'(b), 8, r);
      check("uo_miso_dummy", r, 8'hFF);
    end
    frame_end();
    check("uo_status", host_if.STATUS, 8'h67);
    for (int b = 1; b <= 4; b++) begin
      check("uo_rx_data", host_if.OUTCOMING_DATA, 8'(b));
      host_read();
    end
    check("uo_status_rd", host_if.STATUS, 8'h64);

    // Frame abort after 3 bits, then clear
    err_clr();
    check("fa_clr0", host_if.STATUS, 8'h04);
    host_write(8'h99);
    frame_begin(2'b00);
    spi_bits(8'h0F, 3, r);
    check("fa_partial_miso", r, 8'h04);
    frame_end();
    check("fa_status", host_if.STATUS, 8'h84);
    check("fa_out", host_if.OUTCOMING_DATA, 8'h00);
    check("fa_miso_z", {7'd0, miso_z}, 8'h01);
    err_clr();
    check("fa_clr1", host_if.STATUS, 8'h04);

    // Abort coincident with ERR_CLR: underrun is cleared, frame error kept
    frame_begin(2'b00);
    check("fc_status_start", host_if.STATUS, 8'h54);
    spi_bits(8'hF0, 3, r);
    repeat (6) @(negedge clk);
    cs = 1'b1;                 // rise seen after two sync stages
    @(negedge clk);
    @(negedge clk);
    host_if.ERR_CLR = 1'b1;    // high at the edge that records FRAME_ERR
    @(negedge clk);
    host_if.ERR_CLR = 1'b0;
    repeat (4) @(negedge clk);
    check("fc_status", host_if.STATUS, 8'h84);
    err_clr();

    // Reset mid-frame with two bytes queued
    host_write(8'h11);
    host_write(8'h22);
    frame_begin(2'b00);
    spi_bits(8'hAA, 4, r);
    repeat (H) @(negedge clk);
    s_clk = 1'b1;
    repeat (2) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("rm_status", host_if.STATUS, 8'h04);
    check("rm_miso_z", {7'd0, miso_z}, 8'h01);
    repeat (3) @(negedge clk);
    s_clk = 1'b0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_begin(2'b00);
    spi_bits(8'h00, 8, r);
    check("rm_next_miso", r, 8'hFF);
    frame_end();
    check("rm_next_status", host_if.STATUS, 8'h45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
